display_arbiter: RTL

- Shares the single 8-digit seven-segment display between NREQ requesters (game modes, score/status sources).
- Uses round-robin arbitration with a guaranteed minimum hold time per owner.
- Drives the d0..d7 digit inputs of the seven-segment driver with the current owner's digits, or blank when nobody owns the display.
- Sits between the game cores and the seven-segment driver in the top level.

---
 rtl/display_pkg.sv | 17 +
 rtl/display_arbiter_rr_picker.sv | 27 ++
 rtl/display_arbiter.sv | 125 ++++++++++++
 3 files changed

// File: rtl/display_pkg.sv
// Shared constants and state encoding for the seven-segment display arbiter.
package display_pkg;

    localparam logic [3:0]  BLANK_DIGIT = 4'hF;
    localparam int unsigned DIGIT_W     = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        OPEN = 2'd2
    } state_e;

    function automatic int unsigned owner_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/display_arbiter_rr_picker.sv
// Combinational round-robin search: first requester at or after start_i that is not excluded.
module rr_picker #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IW   = 2
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   start_i,
    input  logic [NREQ-1:0] excl_i,
    output logic            valid_o,
    output logic [IW-1:0]   winner_o
);

    always_comb begin
        int unsigned idx;
        valid_o  = 1'b0;
        winner_o = '0;
        idx      = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = (32'(start_i) + i) % NREQ;
            if (!valid_o && req_i[idx] && !excl_i[idx]) begin
                valid_o  = 1'b1;
                winner_o = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/display_arbiter.sv
// Round-robin owner of the 8-digit seven-segment display with a minimum hold time per grant.
module display_arbiter #(
    parameter int unsigned NREQ        = 4,
    parameter int unsigned HOLD_CYCLES = 50_000_000,
    parameter logic [3:0]  BLANK_DIGIT = display_pkg::BLANK_DIGIT
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic [NREQ-1:0]                       req,
    input  logic [NREQ*display_pkg::DIGIT_W-1:0]  digits_in,
    output logic [NREQ-1:0]                       grant,
    output logic [3:0]                            d0,
    output logic [3:0]                            d1,
    output logic [3:0]                            d2,
    output logic [3:0]                            d3,
    output logic [3:0]                            d4,
    output logic [3:0]                            d5,
    output logic [3:0]                            d6,
    output logic [3:0]                            d7,
    output logic                                  busy,
    output logic                                  hold_active
);

    import display_pkg::*;

    localparam int unsigned   IW       = owner_w(NREQ);
    localparam int unsigned   CW       = $clog2(HOLD_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_CYCLES - 1);

    state_e               state_q, state_d;
    logic [NREQ-1:0]      grant_q, grant_d;
    logic [IW-1:0]        last_q, last_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [DIGIT_W-1:0]   dig_q, dig_d;
    logic [IW-1:0]        start;
    logic                 pick_valid;
    logic [IW-1:0]        pick_idx;
    logic                 owner_req;
    logic                 take;
    logic                 go_idle;

    // last always names the current owner, so one search start serves every state.
    assign start     = (last_q == IW'(NREQ - 1)) ? '0 : last_q + IW'(1);
    // Masking by grant keeps X on non-owner requests out of the hold decision.
    assign owner_req = |(req & grant_q);

    rr_picker #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_picker (
        .req_i    (req),
        .start_i  (start),
        .excl_i   (grant_q),
        .valid_o  (pick_valid),
        .winner_o (pick_idx)
    );

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        dig_d   = digits_in[DIGIT_W*last_q +: DIGIT_W];
        take    = 1'b0;
        go_idle = 1'b0;

        unique case (state_q)
            IDLE: take = pick_valid;
            HOLD: begin
                if (!owner_req) begin
                    take    = pick_valid;
                    go_idle = !pick_valid;
                end else if (cnt_q == CNT_LAST) begin
                    // A waiting requester rotates in on expiry without an OPEN dwell cycle.
                    take = pick_valid;
                    if (!pick_valid) state_d = OPEN;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            OPEN: begin
                take    = pick_valid;
                go_idle = !owner_req && !pick_valid;
            end
            default: go_idle = 1'b1;
        endcase

        if (take) begin
            state_d           = HOLD;
            grant_d           = '0;
            grant_d[pick_idx] = 1'b1;
            last_d            = pick_idx;
            cnt_d             = '0;
            dig_d             = digits_in[DIGIT_W*pick_idx +: DIGIT_W];
        end
        if (go_idle) begin
            state_d = IDLE;
            grant_d = '0;
            cnt_d   = '0;
        end
        if (state_d == IDLE) dig_d = {8{BLANK_DIGIT}};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= IW'(NREQ - 1);
            cnt_q   <= '0;
            dig_q   <= {8{BLANK_DIGIT}};
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            dig_q   <= dig_d;
        end
    end

    assign grant       = grant_q;
    assign busy        = (state_q != IDLE);
    assign hold_active = (state_q == HOLD);
    assign {d7, d6, d5, d4, d3, d2, d1, d0} = dig_q;

endmodule
